load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage access unit between the EX/MEM pipeline register and DataMemory (word-only write port, async read).
//  Adds byte/halfword loads (sign/zero extended) and byte/halfword stores via a 2-cycle read-modify-write with pipeline stall.
//  Detects misaligned and out-of-range accesses, suppresses them, and latches the faulting address for the exception logic.
// PARAMETERS
//  DATA_WIDTH    32            data/address width; only 32 supported
//  MEMORY_DEPTH  512           words in DataMemory; used for range check
//  BASE_ADDRESS  32'h10010000  byte address of DataMemory word 0
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  MemRead       in   1   load request (from EX/MEM)
//  MemWrite      in   1   store request (from EX/MEM)
//  Size          in   2   00 byte, 01 half, 10 word, 11 reserved
//  LoadUnsigned  in   1   1: zero-extend sub-word loads (lbu/lhu)
//  Address       in   32  byte address
//  StoreData     in   32  rt value; sub-word data in low bits
//  LoadData      out  32  extended load result to MEM/WB
//  Stall         out  1   freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  DmAddress     out  32  byte address to DataMemory, bits[1:0] forced 00
//  DmWriteData   out  32  full word to DataMemory
//  DmMemWrite    out  1   DataMemory write enable
//  DmMemRead     out  1   DataMemory read enable
//  DmReadData    in   32  DataMemory read word (combinational)
//  ExcValid      out  1   sticky address-error flag
//  ExcAddress    out  32  faulting byte address (BadVAddr)
//  ExcClear      in   1   clears ExcValid
// BEHAVIOUR
//  Reset: state IDLE; merge reg, ExcAddress = 0; ExcValid = 0. Combinational outputs with no request: Stall, DmMemWrite, DmMemRead = 0; LoadData = 0.
//  Little-endian lanes: Address[1:0]=0 -> bits 7:0; half at [1]=0 -> bits 15:0.
//  Fault = (half && A[0]) | (word && A[1:0]!=0) | Size==11 | A<BASE | ((A-BASE)>>2)>=MEMORY_DEPTH.
//  Faulting request: DmMemRead/DmMemWrite = 0, LoadData = 0, no stall; next edge ExcValid<=1, ExcAddress<=Address
//   only if ExcValid was 0 (first fault wins). Fault and ExcClear same cycle: fault captured, ExcValid stays 1.
//  MemRead & MemWrite both high: treated as store; LoadData = 0.
//  Load (IDLE): DmMemRead=1 same cycle; lane extracted and extended combinationally; 0 latency, no stall.
//  Word store (IDLE): DmMemWrite=1, DmWriteData=StoreData same cycle; written at edge; no stall.
//  Sub-word store FSM, states IDLE, RMW_WRITE:
//   IDLE + sub-word store: DmMemRead=1, Stall=1, DmMemWrite=0; edge: merge reg <= DmReadData with selected lane(s)
//    replaced by StoreData low bits; addr reg <= word address; -> RMW_WRITE.
//   RMW_WRITE: DmMemWrite=1, DmAddress=addr reg, DmWriteData=merge reg, Stall=0, pipeline inputs ignored; -> IDLE.
//   Pipeline holds inputs stable while Stall=1; the instruction retires at the RMW_WRITE edge.
//  Back-to-back sub-word stores: each costs 2 cycles; second sees first's data (read happens after write edge).
//  Reset in RMW_WRITE: async return to IDLE, write not issued (store lost, pipeline flushed by same reset).
//  Stall never asserted two consecutive cycles.
// STRUCTURE
//  Package mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD codes, state enum {IDLE, RMW_WRITE}, DM_BASE_ADDRESS.
//  Sub-module byte_lane_merge (combinational): insert(word, data, A[1:0], Size) and extract(word, A[1:0], Size, unsigned).
//  Top holds FSM, merge/addr regs, fault check, exception regs.
// TESTING
//  1 Word store 0xDEADBEEF @0x10010004 then lw -> LoadData 0xDEADBEEF, Stall never 1, DmMemWrite 1 cycle.
//  2 Word=0x11223344 @0x10010008; sb 0xAA @0x1001000A -> Stall 1 cycle, write 0x11AA3344; lb -> 0xFFFFFFAA, lbu -> 0x000000AA.
//  3 sh 0x8001 @0x10010010 on 0 -> 0x00008001; lh -> 0xFFFF8001; lhu @+2 -> 0.
//  4 lw @0x10010002 -> no DmMemRead, LoadData 0, next cycle ExcValid 1, ExcAddress 0x10010002; second fault @0x10010801 leaves ExcAddress; ExcClear -> 0.
//  5 sb @0x10010800 (index 512) and @0x1000FFFC -> both flagged, no write; memory unchanged.
//  6 Assert reset during RMW_WRITE of sb -> no DmMemWrite, state IDLE, outputs at reset values; two sb same word back-to-back both merge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path.
//   SIZE_* : access-size codes carried on the Size bus
//   lsuState_t : sub-word store sequencing states
//   DM_BASE_ADDRESS : byte address of DataMemory word 0
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [31:0] DM_BASE_ADDRESS = 32'h10010000;

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } lsuState_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian lane handling for sub-word accesses.
//   memWord      in  32  word read from DataMemory
//   data         in  32  store data, sub-word value in low bits
//   byteOffset   in  2   Address[1:0]
//   size         in  2   access size code
//   loadUnsigned in  1   zero-extend instead of sign-extend on extract
//   inserted     out 32  memWord with the addressed lane(s) replaced by data
//   extracted    out 32  addressed lane(s) of memWord, extended to 32 bits
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] memWord,
  input  logic [31:0] data,
  input  logic [1:0]  byteOffset,
  input  logic [1:0]  size,
  input  logic        loadUnsigned,
  output logic [31:0] inserted,
  output logic [31:0] extracted
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    inserted = memWord;
    case (size)
      SIZE_BYTE: begin
        case (byteOffset)
          2'd0:    inserted[7:0]   = data[7:0];
          2'd1:    inserted[15:8]  = data[7:0];
          2'd2:    inserted[23:16] = data[7:0];
          default: inserted[31:24] = data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (byteOffset[1]) inserted[31:16] = data[15:0];
        else               inserted[15:0]  = data[15:0];
      end
      default: inserted = data;
    endcase
  end

  always_comb begin
    case (byteOffset)
      2'd0:    laneByte = memWord[7:0];
      2'd1:    laneByte = memWord[15:8];
      2'd2:    laneByte = memWord[23:16];
      default: laneByte = memWord[31:24];
    endcase
    laneHalf = byteOffset[1] ? memWord[31:16] : memWord[15:0];

    case (size)
      SIZE_BYTE: extracted = {{24{~loadUnsigned & laneByte[7]}}, laneByte};
      SIZE_HALF: extracted = {{16{~loadUnsigned & laneHalf[15]}}, laneHalf};
      SIZE_WORD: extracted = memWord;
      default:   extracted = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage access unit between EX/MEM and a word-write, async-read DataMemory.
// Sub-word stores are done as a two-cycle read-modify-write with a one-cycle
// stall; misaligned / out-of-range accesses are suppressed and the first
// faulting address is held for the exception logic.
//   clk, reset                      clock, async active-high reset
//   MemRead, MemWrite, Size,
//   LoadUnsigned, Address, StoreData  request from EX/MEM
//   LoadData                        extended load result to MEM/WB
//   Stall                           freeze upstream pipeline this cycle
//   DmAddress, DmWriteData,
//   DmMemWrite, DmMemRead, DmReadData  DataMemory interface
//   ExcValid, ExcAddress, ExcClear  sticky address-error report
module load_store_unit
  import mem_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] BASE_ADDRESS = DM_BASE_ADDRESS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  LoadUnsigned,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] DmAddress,
  output logic [DATA_WIDTH-1:0] DmWriteData,
  output logic                  DmMemWrite,
  output logic                  DmMemRead,
  input  logic [DATA_WIDTH-1:0] DmReadData,
  output logic                  ExcValid,
  output logic [DATA_WIDTH-1:0] ExcAddress,
  input  logic                  ExcClear
);

  lsuState_t             state;
  logic [DATA_WIDTH-1:0] mergeReg;
  logic [DATA_WIDTH-1:0] addrReg;

  logic [DATA_WIDTH-1:0] byteOffsetFromBase;
  logic                  request;
  logic                  misaligned;
  logic                  outOfRange;
  logic                  fault;
  logic                  subWordStore;
  logic [DATA_WIDTH-1:0] insertedWord;
  logic [DATA_WIDTH-1:0] extractedWord;

  byte_lane_merge laneMerge (
    .memWord      (DmReadData),
    .data         (StoreData),
    .byteOffset   (Address[1:0]),
    .size         (Size),
    .loadUnsigned (LoadUnsigned),
    .inserted     (insertedWord),
    .extracted    (extractedWord)
  );

  // Pipeline inputs are ignored in RMW_WRITE, so no request or fault is seen there.
  always_comb begin
    request            = (MemRead | MemWrite) && (state == IDLE);
    byteOffsetFromBase = Address - BASE_ADDRESS;
    misaligned         = ((Size == SIZE_HALF) && Address[0]) ||
                         ((Size == SIZE_WORD) && (Address[1:0] != 2'b00)) ||
                         (Size == SIZE_RSVD);
    outOfRange         = (Address < BASE_ADDRESS) ||
                         ((byteOffsetFromBase >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
    fault              = request && (misaligned || outOfRange);
    subWordStore       = request && !fault && MemWrite && (Size != SIZE_WORD);
  end

  always_comb begin
    LoadData    = '0;
    Stall       = 1'b0;
    DmMemWrite  = 1'b0;
    DmMemRead   = 1'b0;
    DmAddress   = {Address[DATA_WIDTH-1:2], 2'b00};
    DmWriteData = '0;
    if (state == RMW_WRITE) begin
      DmMemWrite  = 1'b1;
      DmAddress   = addrReg;
      DmWriteData = mergeReg;
    end else if (request && !fault) begin
      if (MemWrite) begin
        if (Size == SIZE_WORD) begin
          DmMemWrite  = 1'b1;
          DmWriteData = StoreData;
        end else begin
          DmMemRead = 1'b1;
          Stall     = 1'b1;
        end
      end else begin
        DmMemRead = 1'b1;
        LoadData  = extractedWord;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mergeReg   <= '0;
      addrReg    <= '0;
      ExcValid   <= 1'b0;
      ExcAddress <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (subWordStore) begin
            mergeReg <= insertedWord;
            addrReg  <= {Address[DATA_WIDTH-1:2], 2'b00};
            state    <= RMW_WRITE;
          end
        end
        default: state <= IDLE;
      endcase

      // A clear in the same cycle as a fault lets the new fault be recorded.
      if (fault && (!ExcValid || ExcClear)) begin
        ExcValid   <= 1'b1;
        ExcAddress <= Address;
      end else if (ExcClear) begin
        ExcValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite, loadUnsigned, excClear;
  logic [1:0]  size;
  logic [31:0] address, storeData;
  logic [31:0] LoadData, DmAddress, DmWriteData, DmReadData, ExcAddress;
  logic        Stall, DmMemWrite, DmMemRead, ExcValid;

  int checks = 0;
  int errors = 0;

  // Environment DataMemory (word write, async read)
  logic [31:0] dmem [0:DEPTH-1];
  logic [31:0] dmOff;
  logic        dmInRange;

  // Reference model state: byte-addressed image plus exception registers
  logic [7:0]  refMem [0:4*DEPTH-1];
  logic        expExcValid;
  logic [31:0] expExcAddr;
  logic [31:0] got;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (memRead),
    .MemWrite     (memWrite),
    .Size         (size),
    .LoadUnsigned (loadUnsigned),
    .Address      (address),
    .StoreData    (storeData),
    .LoadData     (LoadData),
    .Stall        (Stall),
    .DmAddress    (DmAddress),
    .DmWriteData  (DmWriteData),
    .DmMemWrite   (DmMemWrite),
    .DmMemRead    (DmMemRead),
    .DmReadData   (DmReadData),
    .ExcValid     (ExcValid),
    .ExcAddress   (ExcAddress),
    .ExcClear     (excClear)
  );

  assign dmOff      = DmAddress - BASE;
  assign dmInRange  = (DmAddress >= BASE) && (dmOff[31:2] < 30'd512);
  assign DmReadData = dmInRange ? dmem[dmOff[10:2]] : '0;

  always @(posedge clk) begin
    if (DmMemWrite && dmInRange) dmem[dmOff[10:2]] <= DmWriteData;
  end

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic isFault(input logic [1:0] sz, input logic [31:0] a);
    longint unsigned ua;
    longint unsigned nBytes;
    ua = 64'(a);
    if (sz == 2'b11) return 1'b1;
    if (ua < 64'(BASE)) return 1'b1;
    if ((ua - 64'(BASE)) / 4 >= 64'(DEPTH)) return 1'b1;
    nBytes = 64'(1) << sz;
    return (ua % nBytes) != 0;
  endfunction

  function automatic logic [31:0] wordAt(input int off);
    int base4;
    base4 = off - (off % 4);
    return 32'(refMem[base4]) + 32'(refMem[base4+1]) * 256 +
           32'(refMem[base4+2]) * 65536 + 32'(refMem[base4+3]) * 16777216;
  endfunction

  function automatic logic [31:0] loadValue(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int off;
    logic [31:0] v;
    off = int'(a - BASE);
    case (sz)
      2'b00: begin
        v = 32'(refMem[off]);
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'b01: begin
        v = 32'(refMem[off]) + 32'(refMem[off+1]) * 256;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = wordAt(off);
    endcase
    return v;
  endfunction

  task automatic storeBytes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int off;
    int n;
    off = int'(a - BASE);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) refMem[off+i] = d[8*i +: 8];
  endtask

  task automatic excStep(input logic flt, input logic clr, input logic [31:0] a);
    if (flt && (!expExcValid || clr)) begin
      expExcValid = 1'b1;
      expExcAddr  = a;
    end else if (clr) begin
      expExcValid = 1'b0;
    end
  endtask

  // One pipeline access; called just after a rising edge, returns just after one.
  task automatic doAccess(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input logic clr,
                          output logic [31:0] loadSeen);
    logic flt, isLoad, wordStore, subStore, clr2;
    logic [31:0] wordAddr, expLoad;
    int off;
    memRead = rd; memWrite = wr; size = sz; loadUnsigned = uns;
    address = a; storeData = d; excClear = clr;
    flt       = (rd || wr) && isFault(sz, a);
    isLoad    = rd && !wr && !flt;
    wordStore = wr && !flt && (sz == 2'b10);
    subStore  = wr && !flt && (sz != 2'b10);
    wordAddr  = {a[31:2], 2'b00};
    expLoad   = isLoad ? loadValue(sz, uns, a) : 32'h0;

    @(negedge clk);
    loadSeen = LoadData;
    checkEq("LoadData", LoadData, expLoad);
    checkEq("DmMemRead", 32'(DmMemRead), 32'(isLoad || subStore));
    checkEq("DmMemWrite", 32'(DmMemWrite), 32'(wordStore));
    checkEq("Stall", 32'(Stall), 32'(subStore));
    if (!flt && (rd || wr)) checkEq("DmAddress", DmAddress, wordAddr);
    if (wordStore) checkEq("DmWriteData", DmWriteData, d);
    checkEq("ExcValid", 32'(ExcValid), 32'(expExcValid));
    checkEq("ExcAddress", ExcAddress, expExcAddr);

    @(posedge clk);
    excStep(flt, clr, a);
    if (wordStore) storeBytes(sz, a, d);
    #1;

    if (subStore) begin
      storeBytes(sz, a, d);
      off = int'(a - BASE);
      // pipeline inputs are don't-care while the merged word is written
      memRead = 1'($urandom); memWrite = 1'($urandom); size = 2'($urandom);
      address = $urandom; storeData = $urandom; loadUnsigned = 1'($urandom);
      clr2 = ($urandom_range(0, 3) == 0);
      excClear = clr2;
      @(negedge clk);
      checkEq("RMW DmMemWrite", 32'(DmMemWrite), 32'h1);
      checkEq("RMW DmMemRead", 32'(DmMemRead), 32'h0);
      checkEq("RMW Stall", 32'(Stall), 32'h0);
      checkEq("RMW LoadData", LoadData, 32'h0);
      checkEq("RMW DmAddress", DmAddress, wordAddr);
      checkEq("RMW DmWriteData", DmWriteData, wordAt(off));
      checkEq("RMW ExcValid", 32'(ExcValid), 32'(expExcValid));
      @(posedge clk);
      excStep(1'b0, clr2, 32'h0);
      #1;
    end
  endtask

  task automatic idle(input logic clr);
    logic [31:0] dummy;
    doAccess(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, clr, dummy);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic        rd, wr;
    int          r;

    for (int i = 0; i < DEPTH; i++) dmem[i] = '0;
    for (int i = 0; i < 4*DEPTH; i++) refMem[i] = '0;
    expExcValid = 1'b0;
    expExcAddr  = '0;
    reset = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; size = 2'b10; loadUnsigned = 1'b0;
    address = BASE; storeData = '0; excClear = 1'b0;

    #2;
    checkEq("reset Stall", 32'(Stall), 32'h0);
    checkEq("reset DmMemWrite", 32'(DmMemWrite), 32'h0);
    checkEq("reset DmMemRead", 32'(DmMemRead), 32'h0);
    checkEq("reset LoadData", LoadData, 32'h0);
    checkEq("reset ExcValid", 32'(ExcValid), 32'h0);
    checkEq("reset ExcAddress", ExcAddress, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // word store then word load
    doAccess(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, 1'b0, got);
    doAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, 1'b0, got);
    checkEq("T1 lw", got, 32'hDEADBEEF);

    // byte store into an existing word
    doAccess(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010008, 32'h11223344, 1'b0, got);
    doAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001000A, 32'h000000AA, 1'b0, got);
    doAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, 1'b0, got);
    checkEq("T2 lw", got, 32'h11AA3344);
    doAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001000A, 32'h0, 1'b0, got);
    checkEq("T2 lb", got, 32'hFFFFFFAA);
    doAccess(1'b1, 1'b0, 2'b00, 1'b1, 32'h1001000A, 32'h0, 1'b0, got);
    checkEq("T2 lbu", got, 32'h000000AA);

    // halfword store / loads
    doAccess(1'b0, 1'b1, 2'b01, 1'b0, 32'h10010010, 32'h00008001, 1'b0, got);
    doAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, 1'b0, got);
    checkEq("T3 lw", got, 32'h00008001);
    doAccess(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010010, 32'h0, 1'b0, got);
    checkEq("T3 lh", got, 32'hFFFF8001);
    doAccess(1'b1, 1'b0, 2'b01, 1'b1, 32'h10010012, 32'h0, 1'b0, got);
    checkEq("T3 lhu", got, 32'h00000000);

    // faults: first wins, clear, clear+fault together
    doAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, 1'b0, got);
    checkEq("T4 fault LoadData", got, 32'h0);
    checkEq("T4 ExcValid", 32'(ExcValid), 32'h1);
    checkEq("T4 ExcAddress", ExcAddress, 32'h10010002);
    doAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h10010801, 32'h0, 1'b0, got);
    checkEq("T4 first wins", ExcAddress, 32'h10010002);
    idle(1'b1);
    checkEq("T4 cleared", 32'(ExcValid), 32'h0);
    doAccess(1'b1, 1'b0, 2'b11, 1'b0, 32'h10010004, 32'h0, 1'b0, got);
    checkEq("T4 reserved size", ExcAddress, 32'h10010004);
    doAccess(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010005, 32'h0, 1'b1, got);
    checkEq("T4 clear+fault valid", 32'(ExcValid), 32'h1);
    checkEq("T4 clear+fault addr", ExcAddress, 32'h10010005);
    idle(1'b1);

    // out-of-range sub-word stores
    doAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h10010800, 32'h000000EE, 1'b0, got);
    doAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h1000FFFC, 32'h000000EE, 1'b0, got);
    checkEq("T5 ExcAddress", ExcAddress, 32'h10010800);
    checkEq("T5 last word", dmem[DEPTH-1], 32'h0);

    // reset during RMW_WRITE
    memRead = 1'b0; memWrite = 1'b1; size = 2'b00; loadUnsigned = 1'b0;
    address = 32'h10010020; storeData = 32'h00000055; excClear = 1'b0;
    @(negedge clk);
    checkEq("T6 Stall", 32'(Stall), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    memWrite = 1'b0;
    #1;
    checkEq("T6 DmMemWrite", 32'(DmMemWrite), 32'h0);
    checkEq("T6 Stall after reset", 32'(Stall), 32'h0);
    checkEq("T6 ExcValid", 32'(ExcValid), 32'h0);
    checkEq("T6 ExcAddress", ExcAddress, 32'h0);
    @(negedge clk);
    checkEq("T6 LoadData", LoadData, 32'h0);
    reset = 1'b0;
    expExcValid = 1'b0;
    expExcAddr  = '0;
    @(posedge clk);
    #1;
    doAccess(1'b1, 1'b0, 2'b00, 1'b1, 32'h10010020, 32'h0, 1'b0, got);
    checkEq("T6 store lost", got, 32'h0);
    doAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h10010024, 32'h00000012, 1'b0, got);
    doAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h10010025, 32'h00000034, 1'b0, got);
    doAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010024, 32'h0, 1'b0, got);
    checkEq("T6 back-to-back", got, 32'h00003412);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 32'd2040 + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      rd = 1'($urandom);
      wr = 1'($urandom);
      doAccess(rd, wr, sz, 1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0), got);
    end

    for (int i = 0; i < DEPTH; i++) checkEq("memory image", dmem[i], wordAt(4*i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
